spi_slave_engine: RTL and testbench

SPI_SLAVE_ENGINE -- requirements
Module: spi_slave_engine

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 47 ++++
 rtl/spi_slave_engine.sv | 162 ++++++++++++++++
 tb/tb_spi_slave_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave engine.
package spi_pkg;

  localparam int         SPI_DATA_W    = 8;
  localparam logic [7:0] SPI_IDLE_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer; the edge channel also gets registered rise/fall
// strobes, the level channels are synchronized only.
module spi_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         edge_i,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] lvl_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [W-1:0] lvl_meta_q;
  logic [W-1:0] lvl_q;
  logic         edge_meta_q;
  logic         edge_q;
  logic         prev_q;
  logic         rise_q;
  logic         fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lvl_meta_q  <= '0;
      lvl_q       <= '0;
      edge_meta_q <= 1'b0;
      edge_q      <= 1'b0;
      prev_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      lvl_meta_q  <= lvl_i;
      lvl_q       <= lvl_meta_q;
      edge_meta_q <= edge_i;
      edge_q      <= edge_meta_q;
      prev_q      <= edge_q;
      rise_q      <= edge_q & ~prev_q;
      fall_q      <= ~edge_q & prev_q;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI slave frame engine: oversamples the SPI pins on PCLK, shifts one
// DATA_W-bit frame at a time and hands received bytes to a consumer.
module spi_slave_engine
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_FILL = DATA_W'(SPI_IDLE_FILL)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              sclk_in,
  input  logic              ss_in,
  input  logic              mosi_in,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              spiswai,
  input  logic [1:0]        spi_mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = $clog2(DATA_W);

  logic [1:0] lvl_s;
  logic       ss_s;
  logic       mosi_s;
  logic       sclk_rise;
  logic       sclk_fall;

  spi_sync_edge #(.W(2)) u_sync (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .edge_i (sclk_in),
    .lvl_i  ({mosi_in, ss_in}),
    .lvl_o  (lvl_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign ss_s   = lvl_s[0];
  assign mosi_s = lvl_s[1];

  spi_state_e        state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] tx_buf_q;
  logic              tx_full_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              overrun_q;
  logic              done_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsbfe_q;

  logic enable;
  logic sample_edge;
  logic shift_edge;
  logic last_bit;

  assign enable      = ~spiswai & ~spi_mode[1];
  assign sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
  assign shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;
  assign last_bit    = (bit_cnt_q == CW'(DATA_W - 1));

  // Shift edges only advance once a bit has been sampled, which skips both
  // the leading shift edge (cpha=1) and the trailing edge of the previous
  // frame that lands after a back-to-back reload (cpha=0).
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= IDLE_FILL;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsbfe_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;

      if (tx_load && !tx_full_q) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end

      if (done_q) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
        overrun_q  <= rx_valid_q & ~rx_ack;
      end else if (rx_ack) begin
        rx_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (!ss_s && enable) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          cpol_q     <= cpol;
          cpha_q     <= cpha;
          lsbfe_q    <= lsbfe;
          tx_shift_q <= tx_full_q ? tx_buf_q : IDLE_FILL;
          if (tx_full_q) tx_full_q <= 1'b0;
          bit_cnt_q  <= '0;
          rx_shift_q <= '0;
          state_q    <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (ss_s || !enable) begin
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= lsbfe_q ?
                {mosi_s, rx_shift_q[DATA_W-1:1]} :
                {rx_shift_q[DATA_W-2:0], mosi_s};
              if (last_bit) begin
                bit_cnt_q <= '0;
                done_q    <= 1'b1;
                state_q   <= ST_LOAD;
              end else begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
              end
            end
            if (shift_edge && bit_cnt_q != '0) begin
              tx_shift_q <= lsbfe_q ?
                {1'b0, tx_shift_q[DATA_W-1:1]} :
                {tx_shift_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso     = lsbfe_q ? tx_shift_q[0] : tx_shift_q[DATA_W-1];
  assign miso_oe  = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Randomized bench for spi_slave_engine: a bit-banged SPI master, a
// transaction-level model of the TX buffer and an RX scoreboard.
module tb_spi_slave_engine;

  localparam int H = 6;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       sclk_in, ss_in, mosi_in;
  logic       cpol, cpha, lsbfe, spiswai;
  logic [1:0] spi_mode;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack;
  logic       miso, miso_oe, busy, overrun;

  spi_slave_engine dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .sclk_in  (sclk_in),
    .ss_in    (ss_in),
    .mosi_in  (mosi_in),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsbfe    (lsbfe),
    .spiswai  (spiswai),
    .spi_mode (spi_mode),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_cap = 0;
  int ovr_cnt = 0;
  bit auto_ack = 1'b1;
  logic [7:0] sb_q[$];

  bit         tx_pend = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp,
                  $time);
  endtask

  // Monitor: a new byte is presented on a rx_valid rise or an overrun pulse.
  initial begin : mon
    logic pv;
    logic [7:0] exp;
    pv = 1'b0;
    rx_ack = 1'b0;
    forever begin
      @(posedge PCLK);
      #1;
      if ((rx_valid && !pv) || overrun) begin
        if (sb_q.size() == 0) begin
          chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          exp = sb_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(exp));
          chk("rx_latency", 32'(cyc), 32'(last_cap + 4));
        end
      end
      if (overrun) ovr_cnt++;
      pv = rx_valid;
      rx_ack = auto_ack & rx_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic bits(input logic [7:0] mo, input int nb,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      int k;
      k = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi_in = mo[k];
        tick(H);
        mi[k] = miso;
        last_cap = cyc + 1;
        sclk_in = ~cpol;
        tick(H);
        sclk_in = cpol;
      end else begin
        sclk_in = ~cpol;
        mosi_in = mo[k];
        tick(H);
        mi[k] = miso;
        last_cap = cyc + 1;
        sclk_in = cpol;
        tick(H);
      end
    end
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
    sclk_in = cpol;
    tick(8);
    ss_in = 1'b0;
    tick(8);
    bits(mo, 8, mi);
    tick(H);
    ss_in = 1'b1;
    tick(12);
  endtask

  task automatic try_load(input logic [7:0] v);
    chk("tx_ready", 32'(tx_ready), 32'(!tx_pend));
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    if (!tx_pend) begin
      tx_pend = 1'b1;
      tx_byte = v;
    end
  endtask

  task automatic model_frame(input logic [7:0] mo);
    logic [7:0] exp_mi;
    logic [7:0] mi;
    exp_mi = tx_pend ? tx_byte : 8'hFF;
    tx_pend = 1'b0;
    sb_q.push_back(mo);
    frame(mo, mi);
    chk("miso_byte", 32'(mi), 32'(exp_mi));
  endtask

  initial begin : main
    logic [7:0] m1, m2;
    bit saw;
    sclk_in = 0; ss_in = 1; mosi_in = 0;
    cpol = 0; cpha = 0; lsbfe = 0; spiswai = 0; spi_mode = 2'b00;
    tx_data = 0; tx_load = 0;

    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_miso_oe", 32'(miso_oe), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_miso", 32'(miso), 1);
    PRESET = 1'b0;
    tick(10);

    // Mode 0, MSB first, preloaded TX byte
    try_load(8'hA5);
    model_frame(8'h3C);

    // Mode 3, LSB first; second load while full is dropped
    cpol = 1; cpha = 1; lsbfe = 1;
    try_load(8'h96);
    try_load(8'h11);
    model_frame(8'h81);

    // Back-to-back frames without ack or TX data
    cpol = 0; cpha = 0; lsbfe = 0;
    auto_ack = 1'b0;
    ovr_cnt = 0;
    sb_q.push_back(8'h5E);
    sb_q.push_back(8'hC1);
    sclk_in = cpol;
    tick(8);
    ss_in = 1'b0;
    tick(8);
    bits(8'h5E, 8, m1);
    bits(8'hC1, 8, m2);
    tick(H);
    ss_in = 1'b1;
    tick(12);
    chk("b2b_miso1", 32'(m1), 32'hFF);
    chk("b2b_miso2", 32'(m2), 32'hFF);
    chk("b2b_overruns", 32'(ovr_cnt), 1);
    chk("b2b_rx_data", 32'(rx_data), 32'hC1);
    chk("b2b_rx_valid", 32'(rx_valid), 1);
    auto_ack = 1'b1;
    tick(3);
    chk("ack_clears", 32'(rx_valid), 0);

    // Abort after five bits
    sclk_in = cpol;
    tick(8);
    ss_in = 1'b0;
    tick(8);
    bits(8'hE7, 5, m1);
    tick(H);
    ss_in = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("abort_busy", 32'(busy), 0);
    tick(12);
    try_load(8'h3A);
    model_frame(8'h6D);

    // Stop-in-wait mode ignores a toggling bus
    spiswai = 1'b1;
    tick(4);
    ss_in = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(H);
      sclk_in = ~sclk_in;
      mosi_in = i[1];
      if (busy || miso_oe) saw = 1'b1;
    end
    tick(H);
    chk("swai_idle", 32'(saw), 0);
    chk("swai_miso_oe", 32'(miso_oe), 0);
    chk("swai_rx_valid", 32'(rx_valid), 0);
    ss_in = 1'b1;
    sclk_in = 1'b0;
    tick(8);
    spiswai = 1'b0;
    tick(8);

    // Asynchronous reset in the middle of a frame
    try_load(8'h77);
    sclk_in = cpol;
    tick(8);
    ss_in = 1'b0;
    tick(8);
    bits(8'hAB, 3, m1);
    @(posedge PCLK);
    #2;
    PRESET = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_miso_oe", 32'(miso_oe), 0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 1);
    chk("mid_rst_rx_data", 32'(rx_data), 0);
    chk("mid_rst_miso", 32'(miso), 1);
    tx_pend = 1'b0;
    ss_in = 1'b1;
    tick(3);
    PRESET = 1'b0;
    tick(12);
    chk("post_rst_rx_valid", 32'(rx_valid), 0);

    // Randomized frames, some with the engine disabled
    for (int n = 0; n < 30; n++) begin
      int r;
      logic [7:0] mo;
      r = $urandom_range(0, 7);
      cpol = 1'($urandom);
      cpha = 1'($urandom);
      lsbfe = 1'($urandom);
      spiswai = (r == 6);
      spi_mode = (r == 7) ? 2'($urandom_range(2, 3)) : {1'b0, r[0]};
      mo = 8'($urandom);
      if ($urandom_range(0, 1) == 1) try_load(8'($urandom));
      if ($urandom_range(0, 3) == 0) try_load(8'($urandom));
      if (r < 6) begin
        model_frame(mo);
      end else begin
        frame(mo, m1);
        chk("disabled_busy", 32'(busy), 0);
      end
    end
    spiswai = 1'b0;
    spi_mode = 2'b00;
    tick(10);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
